uart_pixel_loader: RTL and testbench
====================================

# uart_pixel_loader

Serial image loader that sits upstream of the processing units: receives 8N1 UART bytes on `rx`, assembles each group of BPP bytes into one SZ-bit pixel, and writes it into the frame RAM that shrink/effects read from. This replaces the fixed ROM contents with host-supplied images. It runs on the system clock and oversamples `rx` with the same half-bit tick constant as the transmit baud generator.

## Interface
- BPP, 3, bytes per pixel
- HIEGHT, 30, image rows
- WIDTH, 30, image columns
- PEXILS, HIEGHT*WIDTH, pixels per frame
- TICK_PER_HALF, 2604, system clocks per half bit (Fsys/(2*baudrate))
- ADDR_W, 10, RAM address width; PEXILS <= 2**ADDR_W
- SZ, 8*BPP, pixel width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- rx  in  1  serial input, idle high, asynchronous to clk
- arm  in  1  one-cycle pulse, already debounced; restarts a frame load
- wr_en  out  1  one-cycle RAM write strobe
- wr_addr  out  ADDR_W  pixel address, 0..PEXILS-1
- wr_data  out  SZ  assembled pixel
- load_done  out  1  frame complete, level
- frame_err  out  1  sticky: at least one stop bit sampled low since the last arm
- busy  out  1  receiver not in IDLE

## Operation
- `rx` passes through a 2-flop synchronizer; all decisions use the synchronized value.
- Receiver FSM: IDLE, START, DATA, STOP.
  - IDLE: a falling edge of synchronized rx -> START, tick counter cleared.
  - START: after TICK_PER_HALF clocks, sample rx. Low -> DATA. High -> IDLE (glitch, no byte, no error).
  - DATA: sample every 2*TICK_PER_HALF clocks, 8 bits, LSB first. After bit 7 -> STOP.
  - STOP: sample after 2*TICK_PER_HALF clocks. High -> byte valid, IDLE. Low -> byte discarded, frame_err set, IDLE.
- Assembler: byte index 0..BPP-1. The first byte of a pixel lands in wr_data[SZ-1:SZ-8] and the last byte in [7:0]. When the byte index wraps, assert wr_en for one cycle with the current wr_addr. wr_addr increments after the write.
- After write number PEXILS, set load_done. While load_done=1, further valid bytes are ignored: no wr_en, and the address stays at PEXILS-1.
- arm: clears the byte index, wr_addr, load_done and frame_err. It does not disturb a byte in flight in the receiver FSM. That byte counts as byte 0 of the new frame.
- A framing error does not advance the byte index. Pixel alignment is preserved only by valid bytes.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, load_done=0, frame_err=0, busy=0. FSM is IDLE and the byte index is 0.
- Reset mid-byte or mid-frame aborts everything immediately, with no partial write.
- Latency from the stop-bit sample of a pixel's last byte to wr_en high is exactly 1 clock. wr_addr and wr_data are stable while wr_en=1.
- load_done rises in the clock after the final wr_en.
- If arm and a byte completion occur in the same cycle, arm wins and the completing byte is discarded.
- Bit period is 2*TICK_PER_HALF clocks. The tick counter width is clog2(2*TICK_PER_HALF).
- busy is high from the START entry through the STOP sample.

## Structure
- Shared package holds SZ/BPP/PEXILS/ADDR_W derivation and the FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3). The same package is used by the Tx side.
- One natural sub-module: `uart_rx_byte` (synchronizer plus FSM, outputs byte/valid/ferr). The pixel assembler and address counter stay in the top level.

## Test plan
Bench parameters: TICK_PER_HALF=4, BPP=3, HIEGHT=WIDTH=2.
- Send bytes 0x12,0x34,0x56 -> one wr_en with wr_addr=0 and wr_data=0x123456, 1 clock after the third stop sample.
- Send 12 bytes -> wr_en at addresses 0,1,2,3, then load_done=1. A 13th byte produces no wr_en.
- Drive a 3-clock low glitch on idle rx -> no byte, frame_err=0, busy returns low.
- Send a byte with its stop bit forced low -> frame_err=1, byte index unchanged. The next 3 valid bytes write address 0.
- Assert arm in the same cycle a pixel's last byte completes -> no wr_en. wr_addr=0, load_done=0, frame_err=0.
- Drive rst low during DATA of the second byte -> all outputs 0 immediately. After release, 3 bytes write address 0.

Source files
------------

// File: rtl/uart_pixel_loader_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and frame geometry helpers.
package uart_pixel_loader_pkg;

  localparam int unsigned DEF_BPP           = 3;
  localparam int unsigned DEF_HIEGHT        = 30;
  localparam int unsigned DEF_WIDTH         = 30;
  localparam int unsigned DEF_TICK_PER_HALF = 2604;
  localparam int unsigned DEF_ADDR_W        = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int unsigned pix_width(input int unsigned bpp);
    return 8 * bpp;
  endfunction

  function automatic int unsigned frame_pixels(input int unsigned h, input int unsigned w);
    return h * w;
  endfunction

endpackage

// File: rtl/uart_pixel_loader_if.sv
// Frame RAM write port driven by the pixel loader.
interface uart_pixel_loader_if
  import uart_pixel_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned SZ     = pix_width(DEF_BPP)
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [SZ-1:0]     wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, falling-edge start detect, mid-bit sampling.
module uart_rx_byte
  import uart_pixel_loader_pkg::*;
#(
  parameter int unsigned TICK_PER_HALF = DEF_TICK_PER_HALF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       busy
);

  localparam int unsigned     CNT_W     = $clog2(2 * TICK_PER_HALF);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(TICK_PER_HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(2 * TICK_PER_HALF - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             meta_q, sync_q, prev_q;

  // Synchronizer and edge-detect history reset to the idle-high line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          rx_valid = sync_q;
          rx_ferr  = !sync_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_byte = shift_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: rtl/uart_pixel_loader.sv
// Assembles BPP received UART bytes per pixel and writes a full frame into the frame RAM.
module uart_pixel_loader
  import uart_pixel_loader_pkg::*;
#(
  parameter int unsigned BPP           = DEF_BPP,
  parameter int unsigned HIEGHT        = DEF_HIEGHT,
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned TICK_PER_HALF = DEF_TICK_PER_HALF,
  parameter int unsigned ADDR_W        = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 arm,
  uart_pixel_loader_if.master  wr,
  output logic                 load_done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned      SZ        = pix_width(BPP);
  localparam int unsigned      PEXILS    = frame_pixels(HIEGHT, WIDTH);
  localparam int unsigned      IDX_W     = (BPP > 1) ? $clog2(BPP) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BPP - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PEXILS - 1);

  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              rx_ferr;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SZ-1:0]     pix_q, pix_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;

  uart_rx_byte #(
    .TICK_PER_HALF (TICK_PER_HALF)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .busy     (busy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      pix_q   <= '0;
      addr_q  <= '0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      pix_q   <= pix_d;
      addr_q  <= addr_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    idx_d   = idx_q;
    pix_d   = pix_q;
    addr_d  = addr_q;
    wr_en_d = 1'b0;
    done_d  = done_q;
    ferr_d  = ferr_q | rx_ferr;

    // Address advances as the write retires; the last pixel parks it and raises done.
    if (wr_en_q) begin
      if (addr_q == LAST_ADDR) done_d = 1'b1;
      else                     addr_d = addr_q + 1'b1;
    end

    if (rx_valid && !done_q) begin
      pix_d = SZ'({pix_q, rx_byte});
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        wr_en_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // arm overrides everything, including a byte completing in the same cycle.
    if (arm) begin
      idx_d   = '0;
      pix_d   = pix_q;
      addr_d  = '0;
      wr_en_d = 1'b0;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
    end
  end

  assign wr.wr_en   = wr_en_q;
  assign wr.wr_addr = addr_q;
  assign wr.wr_data = pix_q;
  assign load_done  = done_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Self-checking bench for uart_pixel_loader: table vectors, corner sequences, random bytes vs a frame model.
module tb_uart_pixel_loader;

  localparam int unsigned T      = 4;
  localparam int unsigned BPP    = 3;
  localparam int unsigned H      = 2;
  localparam int unsigned W      = 2;
  localparam int unsigned PEX    = H * W;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned SZ     = 8 * BPP;
  // Start-bit drive to write strobe: 2 sync flops + edge register, half bit, 8 data bits, stop bit.
  localparam int          LAT    = 3 + T + 8 * 2 * T + 2 * T;

  logic clk = 1'b0;
  logic rst, rx, arm;
  logic load_done, frame_err, busy;

  uart_pixel_loader_if #(.ADDR_W(ADDR_W), .SZ(SZ)) wr_if ();

  uart_pixel_loader #(
    .BPP           (BPP),
    .HIEGHT        (H),
    .WIDTH         (W),
    .TICK_PER_HALF (T),
    .ADDR_W        (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .arm       (arm),
    .wr        (wr_if),
    .load_done (load_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [SZ-1:0]     data;
  } wr_t;

  wr_t  act_q[$];
  wr_t  exp_q[$];
  int   done_rise = -1;
  logic done_prev = 1'b0;
  bit   busy_seen = 1'b0;

  always @(negedge clk) begin
    wr_t w;
    if (wr_if.wr_en === 1'b1) begin
      w.cyc  = cyc;
      w.addr = wr_if.wr_addr;
      w.data = wr_if.wr_data;
      act_q.push_back(w);
    end
    if (load_done === 1'b1 && done_prev !== 1'b1) done_rise = cyc;
    done_prev = load_done;
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a pixel is the concatenation of BPP consecutive good bytes.
  int          m_idx = 0;
  int          m_addr = 0;
  logic [SZ-1:0] m_pix = '0;
  bit          m_done = 1'b0;
  bit          m_ferr = 1'b0;

  task automatic model_clear();
    m_idx  = 0;
    m_addr = 0;
    m_done = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok, input int start);
    wr_t e;
    if (!ok) begin
      m_ferr = 1'b1;
      return;
    end
    if (m_done) return;
    m_pix = (m_idx == 0) ? SZ'(b) : ((m_pix << 8) | SZ'(b));
    m_idx++;
    if (m_idx == BPP) begin
      e.cyc  = start + LAT;
      e.addr = ADDR_W'(m_addr);
      e.data = m_pix;
      exp_q.push_back(e);
      m_idx = 0;
      m_addr++;
      if (m_addr == PEX) m_done = 1'b1;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int last_start;

  task automatic send_byte(input logic [7:0] b, input bit ok);
    last_start = cyc;
    rx = 1'b0;
    tick(2 * T);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(2 * T);
    end
    rx = ok;
    tick(2 * T);
    rx = 1'b1;
    tick(2);
  endtask

  task automatic send(input logic [7:0] b, input bit ok);
    send_byte(b, ok);
    model_byte(b, ok, last_start);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    model_clear();
    tick(2);
  endtask

  task automatic check_writes(input string tag);
    wr_t e, a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (act_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_write: got none expected addr %0d data 0x%0h", tag, e.addr, e.data);
      end else begin
        a = act_q.pop_front();
        chk({tag, "_wr_cyc"},  64'(a.cyc), 64'(e.cyc));
        chk({tag, "_wr_addr"}, 64'(a.addr), 64'(e.addr));
        chk({tag, "_wr_data"}, 64'(a.data), 64'(e.data));
      end
    end
    chk({tag, "_extra_writes"}, 64'(act_q.size()), 64'd0);
    act_q.delete();
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_load_done"}, 64'(load_done), 64'(m_done));
    chk({tag, "_frame_err"}, 64'(frame_err), 64'(m_ferr));
    chk({tag, "_wr_addr"},   64'(wr_if.wr_addr), m_done ? 64'(PEX - 1) : 64'(m_addr));
    chk({tag, "_busy"},      64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [7:0]        b0, b1, b2;
    logic [SZ-1:0]     exp_data;
    logic [ADDR_W-1:0] exp_addr;
  } vec_t;

  vec_t tbl[4];
  int   last_wr;

  initial begin
    tbl[0] = '{8'h12, 8'h34, 8'h56, 24'h123456, 10'd0};
    tbl[1] = '{8'hFF, 8'h00, 8'hA5, 24'hFF00A5, 10'd1};
    tbl[2] = '{8'h00, 8'h00, 8'h01, 24'h000001, 10'd2};
    tbl[3] = '{8'h80, 8'h7F, 8'hC3, 24'h807FC3, 10'd3};

    rst = 1'b0;
    rx  = 1'b1;
    arm = 1'b0;
    tick(3);
    chk("rst_wr_en",     64'(wr_if.wr_en), 64'd0);
    chk("rst_wr_addr",   64'(wr_if.wr_addr), 64'd0);
    chk("rst_wr_data",   64'(wr_if.wr_data), 64'd0);
    chk("rst_load_done", 64'(load_done), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk("rst_busy",      64'(busy), 64'd0);
    rst = 1'b1;
    tick(4);

    // Full frame from the table, then one surplus byte.
    last_wr = -1;
    for (int v = 0; v < 4; v++) begin
      send(tbl[v].b0, 1'b1);
      send(tbl[v].b1, 1'b1);
      send(tbl[v].b2, 1'b1);
      if (act_q.size() > 0) begin
        chk("vec_data", 64'(act_q[0].data), 64'(tbl[v].exp_data));
        chk("vec_addr", 64'(act_q[0].addr), 64'(tbl[v].exp_addr));
        last_wr = act_q[0].cyc;
      end
      check_writes("vec");
    end
    chk("done_rise_cyc", 64'(done_rise), 64'(last_wr + 1));
    check_status("frame_full");
    send(8'h9C, 1'b1);
    check_writes("after_done");
    check_status("after_done");

    // Short low glitch on an idle line.
    do_arm();
    busy_seen = 1'b0;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    chk("glitch_busy_seen", 64'(busy_seen), 64'd1);
    check_writes("glitch");
    check_status("glitch");

    // Framing error between good bytes leaves the byte index alone.
    send(8'h11, 1'b1);
    send(8'hAA, 1'b0);
    check_writes("ferr_mid");
    check_status("ferr_mid");
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    check_writes("ferr_pix");
    check_status("ferr_pix");

    // arm in the exact cycle a pixel's last byte completes.
    send(8'h44, 1'b1);
    send(8'h55, 1'b1);
    fork
      send_byte(8'h66, 1'b1);
      begin
        tick(LAT - 1);
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
      end
    join
    model_clear();
    check_writes("arm_collide");
    check_status("arm_collide");
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    send(8'h03, 1'b1);
    check_writes("arm_after");
    check_status("arm_after");

    // Reset during the data bits of a pixel's second byte.
    send(8'h77, 1'b1);
    check_writes("pre_rst");
    fork
      send_byte(8'h88, 1'b1);
      begin
        tick(30);
        rst = 1'b0;
        #1;
        chk("midrst_wr_en",     64'(wr_if.wr_en), 64'd0);
        chk("midrst_wr_addr",   64'(wr_if.wr_addr), 64'd0);
        chk("midrst_wr_data",   64'(wr_if.wr_data), 64'd0);
        chk("midrst_load_done", 64'(load_done), 64'd0);
        chk("midrst_frame_err", 64'(frame_err), 64'd0);
        chk("midrst_busy",      64'(busy), 64'd0);
      end
    join
    model_clear();
    exp_q.delete();
    check_writes("during_rst");
    tick(3);
    rst = 1'b1;
    tick(3);
    send(8'hDE, 1'b1);
    send(8'hAD, 1'b1);
    send(8'hBE, 1'b1);
    check_writes("post_rst");
    check_status("post_rst");

    // Random bytes with occasional bad stop bits.
    do_arm();
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      bit ok;
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 5) != 0);
      send(b, ok);
      check_writes("rand");
    end
    check_status("rand_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
